// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the pixel-plane VRAM arbiter.
//   VRAMPX_ADDR_W / VRAMPX_DATA_W : VRAM geometry (17-bit address, 8-bit data)
//   rd_state_e                    : CPU read sequencer states
//   wr_entry_t                    : one posted CPU write (address + data)
package vram_pkg;

    localparam int VRAMPX_ADDR_W = 17;
    localparam int VRAMPX_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        RD_WAIT = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [VRAMPX_ADDR_W-1:0] addr;
        logic [VRAMPX_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous FIFO holding posted CPU writes.
//   clk, resetn      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_ent   : enqueue request and entry (ignored when full)
//   pop              : dequeue request (ignored when empty)
//   head             : entry at the read pointer
//   full, empty      : status derived from the occupancy register
// Pointers are log2(DEPTH) bits and wrap naturally; occupancy is one bit wider.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  wr_entry_t push_ent,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wr_entry_t     store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Full is judged on occupancy before this cycle's pop, so a push into a
    // full FIFO is refused even when a pop happens in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries below the occupancy are ever read.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_ent;
    end

endmodule

// File: rtl/vram_px_arbiter.sv
// vram_px_arbiter: shares the single-port pixel-plane VRAM between the pixel
// engine (absolute priority) and the CPU bus (posted writes, ordered reads).
//   clk, resetn                          : clock, async active-low reset
//   gpu_req/gpu_addr -> gpu_q/gpu_valid  : pixel fetch, data one cycle later
//   cpu_start/cpu_we/cpu_addr/cpu_data   : CPU access strobe and operands
//   cpu_q/cpu_done/cpu_busy              : CPU read data, completion, busy
//   mem_addr/mem_d/mem_we/mem_q          : VRAM port (registered read data)
// Optional build macro VRAM_PX_ARBITER_STATS_EN adds stat_clr (in) and
// stat_stall (out, 16-bit saturating count of CPU cycles stalled by video).
// ADDR_W/DATA_W must not exceed the package widths used for FIFO entries.
module vram_px_arbiter
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = VRAMPX_ADDR_W,
    parameter int DATA_W     = VRAMPX_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic [DATA_W-1:0] gpu_q,
    output logic              gpu_valid,
    input  logic              cpu_start,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
`ifdef VRAM_PX_ARBITER_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_stall
`endif
);

    rd_state_e         state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] addr_hold;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_acc;
    logic              rd_acc;
    logic              pop;
    logic              rd_issue;
    wr_entry_t         push_ent;
    wr_entry_t         head;

    assign cpu_busy = (state != IDLE) | fifo_full;
    assign wr_acc   = cpu_start & cpu_we & ~cpu_busy;
    assign rd_acc   = cpu_start & ~cpu_we & ~cpu_busy;

    // Slot priority: video fetch, then posted writes, then the pending read.
    // The read waits for an empty FIFO so it observes every earlier write.
    assign pop      = ~gpu_req & ~fifo_empty;
    assign rd_issue = ~gpu_req & fifo_empty & (state == RD_PEND);

    assign push_ent.addr = VRAMPX_ADDR_W'(cpu_addr);
    assign push_ent.data = VRAMPX_DATA_W'(cpu_data);

    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (wr_acc),
        .push_ent (push_ent),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Idle slots keep the last address on the bus to avoid needless toggling.
    always_comb begin
        mem_addr = addr_hold;
        mem_d    = '0;
        mem_we   = 1'b0;
        if (gpu_req) begin
            mem_addr = gpu_addr;
        end else if (pop) begin
            mem_addr = ADDR_W'(head.addr);
            mem_d    = DATA_W'(head.data);
            mem_we   = 1'b1;
        end else if (rd_issue) begin
            mem_addr = rd_addr;
        end
    end

    assign gpu_q = gpu_valid ? mem_q : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_hold <= '0;
            gpu_valid <= 1'b0;
            cpu_done  <= 1'b0;
        end else begin
            addr_hold <= mem_addr;
            gpu_valid <= gpu_req;
            // Writes are acknowledged as soon as they are posted.
            cpu_done  <= wr_acc | (state == RD_WAIT);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            rd_addr <= '0;
            cpu_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_acc) begin
                        rd_addr <= cpu_addr;
                        state   <= RD_PEND;
                    end
                end
                RD_PEND: begin
                    if (rd_issue) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    cpu_q <= mem_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VRAM_PX_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_stall <= '0;
        end else if (stat_clr) begin
            stat_stall <= '0;
        end else if (gpu_req && (!fifo_empty || state == RD_PEND) &&
                     stat_stall != 16'hFFFF) begin
            stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_px_arbiter.sv
// tb_vram_px_arbiter: directed cycle table, corner sequences (pointer wrap,
// reset during a pending read) and a randomized run checked against a
// transaction-level model of the VRAM and the CPU's view of memory.
module tb_vram_px_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        gpu_req = 1'b0;
    logic [16:0] gpu_addr = '0;
    logic [7:0]  gpu_q;
    logic        gpu_valid;
    logic        cpu_start = 1'b0;
    logic        cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic [7:0]  cpu_q;
    logic        cpu_done;
    logic        cpu_busy;
    logic [16:0] mem_addr;
    logic [7:0]  mem_d;
    logic        mem_we;
    logic [7:0]  mem_q;
`ifdef VRAM_PX_ARBITER_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_stall;
`endif

    always #5 clk = ~clk;

    vram_px_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_q(gpu_q), .gpu_valid(gpu_valid),
        .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
`ifdef VRAM_PX_ARBITER_STATS_EN
        , .stat_clr(stat_clr), .stat_stall(stat_stall)
`endif
    );

    // Power-on RAM contents: a fixed pattern, so 0x1ABCD holds 0x5A.
    function automatic logic [7:0] init_val(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // VRAM: single port, registered read returning the pre-write contents.
    logic [7:0] ram   [131072];
    bit         wr_ok [131072];
    always @(posedge clk) begin
        mem_q <= wr_ok[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
        if (mem_we) begin
            ram[mem_addr]   <= mem_d;
            wr_ok[mem_addr] <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic g, input logic [16:0] ga, input logic cs,
                          input logic cw, input logic [16:0] ca, input logic [7:0] cd);
        gpu_req = g; gpu_addr = ga; cpu_start = cs; cpu_we = cw; cpu_addr = ca; cpu_data = cd;
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct { logic [16:0] a; logic [7:0] d; } wr_t;
    wr_t        wq[$];          // writes accepted but not yet seen on the bus
    logic [7:0] cm [int];       // what VRAM holds (bus writes observed)
    logic [7:0] sh [int];       // what the CPU expects (accepted writes)
    bit         rd_out, exp_wdone, prev_req, mon_en;
    logic [16:0] rd_a;
    logic [7:0]  rd_exp, prev_gq;
    int          rd_age;

    function automatic logic [7:0] cm_rd(input logic [16:0] a);
        return cm.exists(int'(a)) ? cm[int'(a)] : init_val(a);
    endfunction
    function automatic logic [7:0] sh_rd(input logic [16:0] a);
        return sh.exists(int'(a)) ? sh[int'(a)] : init_val(a);
    endfunction

    task automatic model_clear();
        wq.delete();
        sh = cm;
        rd_out = 0; exp_wdone = 0; prev_req = 0; rd_age = 0;
    endtask

    task automatic model_step();
        bit  busy_e, acc;
        wr_t w;
        if (exp_wdone) chk("wr_done", cpu_done, 1);
        else if (cpu_done) begin
            if (rd_out) begin chk("rd_data", cpu_q, rd_exp); rd_out = 0; end
            else chk("spurious_done", cpu_done, 0);
        end
        busy_e = rd_out || (wq.size() == DEPTH);
        chk("busy", cpu_busy, busy_e);
        acc = cpu_start && !busy_e;
        if (gpu_req) begin
            chk("gpu_slot_we", mem_we, 0);
            chk("gpu_slot_addr", mem_addr, gpu_addr);
        end else if (wq.size() > 0) begin
            chk("drain_we", mem_we, 1);
            if (mem_we) begin
                w = wq.pop_front();
                chk("drain_addr", mem_addr, w.a);
                chk("drain_data", mem_d, w.d);
                cm[int'(w.a)] = w.d;
            end
        end else begin
            chk("idle_we", mem_we, 0);
            if (rd_out) chk("rd_addr", mem_addr, rd_a);
        end
        exp_wdone = acc && cpu_we;
        if (acc && cpu_we) begin
            w.a = cpu_addr; w.d = cpu_data;
            wq.push_back(w);
            sh[int'(cpu_addr)] = cpu_data;
        end
        if (acc && !cpu_we) begin
            rd_out = 1; rd_a = cpu_addr; rd_exp = sh_rd(cpu_addr); rd_age = 0;
        end
        if (rd_out) begin
            rd_age++;
            if (rd_age > 400) begin chk("rd_timeout", rd_age, 400); rd_out = 0; end
        end
        chk("gpu_valid", gpu_valid, prev_req);
        if (prev_req) chk("gpu_q", gpu_q, prev_gq);
        prev_req = gpu_req;
        prev_gq  = cm_rd(gpu_addr);
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic g; logic [16:0] ga; logic cs, cw; logic [16:0] ca; logic [7:0] cd;
        logic ewe; logic [16:0] ea; logic [7:0] ed;
        logic edone, ebusy, egv; logic [7:0] egq, ecq;
    } vec_t;

    function automatic vec_t mk(logic g, logic [16:0] ga, logic cs, logic cw,
                                logic [16:0] ca, logic [7:0] cd, logic ewe,
                                logic [16:0] ea, logic [7:0] ed, logic edone,
                                logic ebusy, logic egv, logic [7:0] egq, logic [7:0] ecq);
        vec_t v;
        v.g = g; v.ga = ga; v.cs = cs; v.cw = cw; v.ca = ca; v.cd = cd;
        v.ewe = ewe; v.ea = ea; v.ed = ed; v.edone = edone; v.ebusy = ebusy;
        v.egv = egv; v.egq = egq; v.ecq = ecq;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        //             g ga       cs cw ca      cd     we ea       ed     dn bz gv gq     cq
        tbl[0]  = mk(0, 0,       0, 0, 0,      0,     0, 0,       0,     0, 0, 0, 0,     0);
        tbl[1]  = mk(1, 'h1ABCD, 1, 1, 'h10,   'h11,  0, 'h1ABCD, 0,     0, 0, 0, 0,     0);
        tbl[2]  = mk(1, 'h1ABCD, 1, 1, 'h11,   'h22,  0, 'h1ABCD, 0,     1, 0, 1, 'h5A,  0);
        tbl[3]  = mk(1, 'h1ABCD, 1, 1, 'h12,   'h33,  0, 'h1ABCD, 0,     1, 0, 1, 'h5A,  0);
        tbl[4]  = mk(1, 'h1ABCD, 1, 1, 'h13,   'h44,  0, 'h1ABCD, 0,     1, 0, 1, 'h5A,  0);
        tbl[5]  = mk(1, 'h1ABCD, 1, 1, 'h14,   'h55,  0, 'h1ABCD, 0,     1, 1, 1, 'h5A,  0);
        tbl[6]  = mk(1, 'h1ABCD, 0, 0, 0,      0,     0, 'h1ABCD, 0,     0, 1, 1, 'h5A,  0);
        tbl[7]  = mk(0, 0,       0, 0, 0,      0,     1, 'h10,    'h11,  0, 1, 1, 'h5A,  0);
        tbl[8]  = mk(0, 0,       0, 0, 0,      0,     1, 'h11,    'h22,  0, 0, 0, 0,     0);
        tbl[9]  = mk(0, 0,       0, 0, 0,      0,     1, 'h12,    'h33,  0, 0, 0, 0,     0);
        tbl[10] = mk(0, 0,       0, 0, 0,      0,     1, 'h13,    'h44,  0, 0, 0, 0,     0);
        tbl[11] = mk(0, 0,       0, 0, 0,      0,     0, 'h13,    0,     0, 0, 0, 0,     0);
        tbl[12] = mk(1, 'h200,   1, 1, 'h100,  'h77,  0, 'h200,   0,     0, 0, 0, 0,     0);
        tbl[13] = mk(1, 'h200,   1, 0, 'h100,  0,     0, 'h200,   0,     1, 0, 1, 'h3E,  0);
        tbl[14] = mk(1, 'h200,   0, 0, 0,      0,     0, 'h200,   0,     0, 1, 1, 'h3E,  0);
        tbl[15] = mk(1, 'h200,   0, 0, 0,      0,     0, 'h200,   0,     0, 1, 1, 'h3E,  0);
        tbl[16] = mk(0, 0,       0, 0, 0,      0,     1, 'h100,   'h77,  0, 1, 1, 'h3E,  0);
        tbl[17] = mk(0, 0,       0, 0, 0,      0,     0, 'h100,   0,     0, 1, 0, 0,     0);
        tbl[18] = mk(0, 0,       0, 0, 0,      0,     0, 'h100,   0,     0, 1, 0, 0,     0);
        tbl[19] = mk(0, 0,       0, 0, 0,      0,     0, 'h100,   0,     1, 0, 0, 0,     'h77);

        mon_en = 0;
        model_clear();

        // Reset state, checked while resetn is low.
        #12;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_gpu_valid", gpu_valid, 0);
        chk("rst_cpu_q", cpu_q, 0);
`ifdef VRAM_PX_ARBITER_STATS_EN
        chk("rst_stat", stat_stall, 0);
`endif
        #10 resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].g, tbl[i].ga, tbl[i].cs, tbl[i].cw, tbl[i].ca, tbl[i].cd);
            @(negedge clk);
            chk($sformatf("t%0d mem_we", i), mem_we, tbl[i].ewe);
            chk($sformatf("t%0d mem_addr", i), mem_addr, tbl[i].ea);
            if (tbl[i].ewe) chk($sformatf("t%0d mem_d", i), mem_d, tbl[i].ed);
            chk($sformatf("t%0d cpu_done", i), cpu_done, tbl[i].edone);
            chk($sformatf("t%0d cpu_busy", i), cpu_busy, tbl[i].ebusy);
            chk($sformatf("t%0d gpu_valid", i), gpu_valid, tbl[i].egv);
            chk($sformatf("t%0d gpu_q", i), gpu_q, tbl[i].egq);
            chk($sformatf("t%0d cpu_q", i), cpu_q, tbl[i].ecq);
            @(posedge clk); #1;
        end

        // Pointer wrap: two writes during video, then push+pop every cycle.
        model_clear();
        mon_en = 1;
        for (int i = 0; i < 20; i++) begin
            set_in(i < 2, 17'h300, 1, 1, 17'h300 + 17'(i), 8'hA0 + 8'(i));
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("wrap_drained", wq.size(), 0);
        mon_en = 0;

        // Reset while a read is pending behind three posted writes.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 17'h500, 1, 1, 17'h500 + 17'(i), 8'(i + 1));
            tick();
        end
        set_in(1, 17'h500, 1, 0, 17'h500, 0);
        tick();
        set_in(1, 17'h500, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        chk("pre_rst_busy", cpu_busy, 1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("midrst_busy", cpu_busy, 0);
        chk("midrst_done", cpu_done, 0);
        chk("midrst_gpu_valid", gpu_valid, 0);
        chk("midrst_cpu_q", cpu_q, 0);
`ifdef VRAM_PX_ARBITER_STATS_EN
        chk("midrst_stat", stat_stall, 0);
`endif
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d mem_we", i), mem_we, 0);
            chk($sformatf("postrst%0d cpu_done", i), cpu_done, 0);
            chk($sformatf("postrst%0d cpu_busy", i), cpu_busy, 0);
            @(posedge clk); #1;
        end

        // Randomized traffic at three video loads.
        model_clear();
        mon_en = 1;
        for (int seg = 0; seg < 3; seg++) begin
            int pct;
            pct = (seg == 0) ? 20 : (seg == 1) ? 60 : 85;
            for (int i = 0; i < 1000; i++) begin
                set_in($urandom_range(0, 99) < pct,
                       17'h400 + 17'($urandom_range(0, 31)),
                       $urandom_range(0, 99) < 40,
                       $urandom_range(0, 99) < 70,
                       17'h400 + 17'($urandom_range(0, 15)),
                       8'($urandom));
                tick();
            end
        end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) tick();
        chk("final_wq_empty", wq.size(), 0);
        chk("final_no_read", rd_out, 0);
        mon_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
